// File: rtl/ntt_pkg.sv
// Shared constants, types and mod-Q arithmetic for the N=8, Q=17 NTT blocks.
package ntt_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned Q     = 17;
  localparam int unsigned W     = 8;
  localparam int unsigned LOGN  = 3;
  localparam int unsigned N_INV = 15;

  typedef logic [W-1:0] coeff_t;

  // Inverse twiddles: powers of w^-1 = 9 mod 17
  localparam coeff_t INV_TW [0:3] = '{8'd1, 8'd9, 8'd13, 8'd15};

  typedef enum logic [1:0] {IDLE, BFLY, SCALE, DONE} intt_state_e;

  function automatic coeff_t modadd(input coeff_t x, input coeff_t y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= (W+1)'(Q)) ? coeff_t'(s - (W+1)'(Q)) : coeff_t'(s);
  endfunction

  function automatic coeff_t modsub(input coeff_t x, input coeff_t y);
    return (x >= y) ? coeff_t'(x - y) : coeff_t'(x + coeff_t'(Q) - y);
  endfunction

  function automatic coeff_t modmul(input coeff_t x, input coeff_t y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return coeff_t'(p % (2*W)'(Q));
  endfunction

  function automatic coeff_t modred(input coeff_t x);
    return coeff_t'(x % coeff_t'(Q));
  endfunction

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] i);
    logic [LOGN-1:0] r;
    for (int unsigned b = 0; b < LOGN; b++) r[b] = i[LOGN-1-b];
    return r;
  endfunction

endpackage

// File: rtl/intt_engine_if.sv
// Data/handshake bundle between the inverse-NTT engine and its producer/consumer.
interface intt_engine_if import ntt_pkg::*; ();

  coeff_t [N-1:0] a;
  logic           intt_start;
  coeff_t [N-1:0] out;
  logic           intt_busy;
  logic           intt_done;

  modport master (output a, intt_start, input out, intt_busy, intt_done);
  modport slave  (input a, intt_start, output out, intt_busy, intt_done);

endinterface

// File: rtl/intt_butterfly.sv
// Combinational Cooley-Tukey butterfly: y0 = x0 + tw*x1, y1 = x0 - tw*x1 (mod Q).
module intt_butterfly import ntt_pkg::*; (
  input  coeff_t x0,
  input  coeff_t x1,
  input  coeff_t tw,
  output coeff_t y0,
  output coeff_t y1
);

  coeff_t t;

  always_comb begin
    t  = modmul(tw, x1);
    y0 = modadd(x0, t);
    y1 = modsub(x0, t);
  end

endmodule

// File: rtl/intt_engine.sv
// Sequential inverse NTT: bit-reversed load, 12 DIT butterflies, then 8-cycle scale by N^-1.
module intt_engine import ntt_pkg::*; (
  input logic          clk,
  input logic          rst_n,
  intt_engine_if.slave bus
);

  intt_state_e state, nxt;

  logic [1:0]      stage;
  logic [1:0]      k;
  logic [LOGN-1:0] idx;
  coeff_t          mem [N];

  logic [LOGN-1:0] len, pos, i0, i1;
  logic [1:0]      tw_idx;
  coeff_t          y0, y1, scaled;
  logic            accept, last_bfly;

  assign accept    = bus.intt_start && (state == IDLE || state == DONE);
  assign last_bfly = (stage == 2'd2) && (k == 2'd3);

  // Butterfly k of stage s touches (i0, i0+len) with twiddle index pos*N/(2*len)
  always_comb begin
    len    = LOGN'(1) << stage;
    pos    = LOGN'(k) & (len - LOGN'(1));
    i0     = ((LOGN'(k) >> stage) << (stage + 2'd1)) | pos;
    i1     = i0 | len;
    tw_idx = 2'(pos << (2'd2 - stage));
    scaled = modmul(mem[idx], coeff_t'(N_INV));
  end

  intt_butterfly u_bfly (
    .x0 (mem[i0]),
    .x1 (mem[i1]),
    .tw (INV_TW[tw_idx]),
    .y0 (y0),
    .y1 (y1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (bus.intt_start) nxt = BFLY;
      BFLY:  if (last_bfly) nxt = SCALE;
      SCALE: if (idx == LOGN'(N-1)) nxt = DONE;
      DONE:  nxt = bus.intt_start ? BFLY : IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign bus.intt_busy = (state == BFLY) || (state == SCALE);
  assign bus.intt_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage   <= '0;
      k       <= '0;
      idx     <= '0;
      bus.out <= '0;
      for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
    end else if (accept) begin
      stage <= '0;
      k     <= '0;
      for (int unsigned i = 0; i < N; i++) mem[bitrev(LOGN'(i))] <= modred(bus.a[i]);
    end else begin
      case (state)
        BFLY: begin
          mem[i0] <= y0;
          mem[i1] <= y1;
          k       <= k + 2'd1;
          if (k == 2'd3) stage <= stage + 2'd1;
          if (last_bfly) idx <= '0;
        end
        SCALE: begin
          mem[idx] <= scaled;
          idx      <= idx + LOGN'(1);
          // Final product bypasses mem so out is complete on the DONE edge
          if (idx == LOGN'(N-1)) begin
            for (int unsigned i = 0; i < N-1; i++) bus.out[i] <= mem[i];
            bus.out[N-1] <= scaled;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
